// File: rtl/square_motion_pkg.sv
// square_motion_pkg: shared visible-area, colour and RUN/PAUSE state definitions for square_motion.
package square_motion_pkg;
    localparam int          H_MAX_DEF  = 640;
    localparam int          V_MAX_DEF  = 480;
    localparam logic [11:0] SQ_RGB_DEF = 12'hF00;
    localparam logic [11:0] BG_RGB_DEF = 12'h00F;
    localparam logic [11:0] BLACK      = 12'h000;
    typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_t;
endpackage

// File: rtl/square_motion_btn_sync.sv
// btn_sync: 2-flop synchronizer for one raw pushbutton plus a one-cycle rising-edge pulse.
//   clk   : system clock
//   reset : asynchronous active-low reset, clears all flops
//   btn   : raw asynchronous button
//   level : synchronized button level
//   rise  : one-cycle pulse on each synchronized 0->1 transition
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);
    logic [2:0] sh;
    always_ff @(posedge clk or negedge reset)
        if (!reset) sh <= '0;
        else        sh <= {sh[1:0], btn};
    assign level = sh[1];
    assign rise  = sh[1] & ~sh[2];
endmodule

// File: rtl/square_motion.sv
// square_motion: moves a square once per frame and paints it over a background colour.
//   clk_100MHz      : system clock
//   reset           : asynchronous active-low reset
//   video_on        : visible-area flag; rgb is black outside it
//   p_tick, x, y    : pixel strobe and coordinates; x=0,y=V_MAX+1 on p_tick marks a frame
//   btn_*           : raw active-high pushbuttons, synchronized internally
//   rgb             : combinational pixel colour
//   sq_x, sq_y      : registered top-left corner of the square
// Build option SQ_BOUNCE_EN: the square bounces on its own and direction buttons are ignored;
// otherwise it follows the held direction buttons.
module square_motion
    import square_motion_pkg::*;
#(
    parameter int          SQ_SIZE = 64,
    parameter int          VEL     = 1,
    parameter int          H_MAX   = H_MAX_DEF,
    parameter int          V_MAX   = V_MAX_DEF,
    parameter logic [11:0] SQ_RGB  = SQ_RGB_DEF,
    parameter logic [11:0] BG_RGB  = BG_RGB_DEF
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        video_on,
    input  logic        p_tick,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_pause,
    output logic [11:0] rgb,
    output logic [9:0]  sq_x,
    output logic [9:0]  sq_y
);
    localparam logic [10:0] X_LIM   = 11'(H_MAX - SQ_SIZE);
    localparam logic [10:0] Y_LIM   = 11'(V_MAX - SQ_SIZE);
    localparam logic [10:0] STEP    = 11'(VEL);
    localparam logic [10:0] SIZE    = 11'(SQ_SIZE);
    localparam logic [9:0]  X0      = 10'((H_MAX - SQ_SIZE) / 2);
    localparam logic [9:0]  Y0      = 10'((V_MAX - SQ_SIZE) / 2);
    localparam logic [9:0]  FRAME_Y = 10'(V_MAX + 1);

    // bit order: pause, right, left, down, up
    logic [4:0] raw, lvl, rise;
    assign raw = {btn_pause, btn_right, btn_left, btn_down, btn_up};
    for (genvar i = 0; i < 5; i++) begin : g_sync
        btn_sync u_sync (.clk(clk_100MHz), .reset(reset), .btn(raw[i]), .level(lvl[i]), .rise(rise[i]));
    end

    function automatic logic [9:0] inc(input logic [9:0] p, input logic [10:0] lim);
        logic [10:0] s;
        s = {1'b0, p} + STEP;
        return s > lim ? lim[9:0] : s[9:0];
    endfunction

    function automatic logic [9:0] dec(input logic [9:0] p);
        return {1'b0, p} < STEP ? 10'd0 : p - STEP[9:0];
    endfunction

    state_t     state, st_n;
    logic       frame_tick, frame_q, sq_on;
    logic [9:0] nx, ny;
    logic       unused_btn;

    assign frame_tick = p_tick && x == 10'd0 && y == FRAME_Y;
    // a pause edge in the move cycle is applied before deciding whether to move
    assign st_n = rise[4] ? (state == RUN ? PAUSE : RUN) : state;

`ifdef SQ_BOUNCE_EN
    logic dir_r, dir_d, nr, nd;
    assign unused_btn = ^{lvl, rise[3:0]};
    assign nx = dir_r ? inc(sq_x, X_LIM) : dec(sq_x);
    assign ny = dir_d ? inc(sq_y, Y_LIM) : dec(sq_y);
    // flip as soon as the update lands on a bound, so the next frame already moves away
    assign nr = dir_r ? ({1'b0, sq_x} + STEP < X_LIM) : ({1'b0, sq_x} <= STEP);
    assign nd = dir_d ? ({1'b0, sq_y} + STEP < Y_LIM) : ({1'b0, sq_y} <= STEP);
`else
    assign unused_btn = ^{lvl[4], rise[3:0]};
    assign nx = (lvl[3] & ~lvl[2]) ? inc(sq_x, X_LIM) : (lvl[2] & ~lvl[3]) ? dec(sq_x) : sq_x;
    assign ny = (lvl[1] & ~lvl[0]) ? inc(sq_y, Y_LIM) : (lvl[0] & ~lvl[1]) ? dec(sq_y) : sq_y;
`endif

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            frame_q <= 1'b0;
            sq_x    <= X0;
            sq_y    <= Y0;
`ifdef SQ_BOUNCE_EN
            dir_r   <= 1'b1;
            dir_d   <= 1'b1;
`endif
        end else begin
            state   <= st_n;
            frame_q <= frame_tick;
            if (frame_q && st_n == RUN) begin
                sq_x  <= nx;
                sq_y  <= ny;
`ifdef SQ_BOUNCE_EN
                dir_r <= nr;
                dir_d <= nd;
`endif
            end
        end
    end

    // 11-bit compares keep sq+SIZE from wrapping near the right/bottom edge
    assign sq_on = {1'b0, x} >= {1'b0, sq_x} && {1'b0, x} < {1'b0, sq_x} + SIZE &&
                   {1'b0, y} >= {1'b0, sq_y} && {1'b0, y} < {1'b0, sq_y} + SIZE;
    assign rgb = !video_on ? BLACK : sq_on ? SQ_RGB : BG_RGB;
endmodule

// File: tb/tb_square_motion.sv
// tb_square_motion: directed stimulus with a queued scoreboard for square_motion.
module tb_square_motion;
    logic        clk_100MHz = 0, reset = 0, video_on = 0, p_tick = 0;
    logic [9:0]  x = 0, y = 0;
    logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_pause = 0;
    logic [11:0] rgb;
    logic [9:0]  sq_x, sq_y;

`ifdef SQ_BOUNCE_EN
    localparam int DY = 1;
`else
    localparam int DY = 0;
`endif

    square_motion dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .video_on(video_on), .p_tick(p_tick),
        .x(x), .y(y), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_pause(btn_pause), .rgb(rgb), .sq_x(sq_x), .sq_y(sq_y)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        string       name;
        int          sel;
        logic [11:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   ex, ey;

    // monitor: drains every pending expectation at the falling edge
    always @(negedge clk_100MHz) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [11:0] got;
            e   = q.pop_front();
            got = e.sel == 0 ? rgb : e.sel == 1 ? {2'b00, sq_x} : {2'b00, sq_y};
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got %0d (0x%h) want %0d (0x%h) at %0t", e.name, got, got, e.val, e.val, $time);
            end
        end
    end

    task automatic sync();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic push(input string n, input int s, input int v);
        q.push_back('{n, s, 12'(v)});
    endtask

    task automatic want_pos(input string n, input int px, input int py);
        push({n, ".sq_x"}, 1, px);
        push({n, ".sq_y"}, 2, py);
        sync();
    endtask

    task automatic want_rgb(input string n, input logic von, input int px, input int py, input int v);
        video_on = von;
        x = 10'(px);
        y = 10'(py);
        push(n, 0, v);
        sync();
        video_on = 0;
        x = 0;
        y = 0;
    endtask

    // one frame marker followed by the cycle in which the move is applied
    task automatic frame();
        p_tick = 1;
        x = 0;
        y = 10'd481;
        sync();
        p_tick = 0;
        y = 0;
        sync();
    endtask

    task automatic settle();
        repeat (4) sync();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) sync();
        reset = 1;
        sync();
        want_pos("reset", 288, 208);
        want_rgb("rgb_in", 1, 300, 220, 12'hF00);
        want_rgb("rgb_out", 1, 0, 0, 12'h00F);
        want_rgb("rgb_blank", 0, 300, 220, 12'h000);
        want_rgb("rgb_left_edge_in", 1, 288, 208, 12'hF00);
        want_rgb("rgb_left_edge_out", 1, 287, 220, 12'h00F);
        want_rgb("rgb_right_edge_in", 1, 351, 271, 12'hF00);
        want_rgb("rgb_right_edge_out", 1, 352, 220, 12'h00F);
        want_rgb("rgb_bottom_out", 1, 300, 272, 12'h00F);

`ifdef SQ_BOUNCE_EN
        for (int k = 1; k <= 289; k++) begin
            frame();
            if (k <= 3) want_pos("bounce_start", 288 + k, 208 + k);
            if (k == 208 || k == 209) want_pos("bounce_y", 288 + k, k == 208 ? 416 : 415);
            if (k == 288) want_pos("bounce_x_hit", 576, 336);
            if (k == 289) want_pos("bounce_x_back", 575, 335);
        end
`else
        for (int k = 1; k <= 3; k++) begin
            frame();
            want_pos("idle", 288, 208);
        end
        btn_right = 1;
        settle();
        for (int k = 1; k <= 400; k++) begin
            frame();
            want_pos("right_sat", 288 + k > 576 ? 576 : 288 + k, 208);
        end
        btn_left = 1;
        settle();
        for (int k = 0; k < 3; k++) begin
            frame();
            want_pos("left_right_cancel", 576, 208);
        end
        btn_right = 0;
        btn_left = 0;
        btn_down = 1;
        settle();
        for (int k = 1; k <= 250; k++) begin
            frame();
            want_pos("down_sat", 576, 208 + k > 416 ? 416 : 208 + k);
        end
        btn_up = 1;
        settle();
        for (int k = 0; k < 2; k++) begin
            frame();
            want_pos("up_down_cancel", 576, 416);
        end
        btn_down = 0;
        btn_left = 1;
        settle();
        for (int k = 1; k <= 3; k++) begin
            frame();
            want_pos("left_up", 576 - k, 416 - k);
        end
        btn_left = 0;
        btn_up = 0;
        settle();
`endif

        // asynchronous reset in the middle of a frame
        y = 10'd100;
        reset = 0;
        push("midframe_reset.sq_x", 1, 288);
        push("midframe_reset.sq_y", 2, 208);
        sync();
        sync();
        reset = 1;
        btn_right = 1;
        settle();
        ex = 288;
        ey = 208;
        for (int k = 0; k < 2; k++) begin
            frame();
            ex++;
            ey += DY;
            want_pos("after_reset_move", ex, ey);
        end

        btn_pause = 1;
        settle();
        for (int k = 0; k < 5; k++) begin
            frame();
            want_pos("paused_held", ex, ey);
        end
        btn_pause = 0;
        settle();
        for (int k = 0; k < 10; k++) begin
            frame();
            want_pos("paused_idle", ex, ey);
        end
        btn_pause = 1;
        settle();
        frame();
        ex++;
        ey += DY;
        want_pos("resume", ex, ey);
        btn_pause = 0;
        btn_right = 0;

        sync();
        sync();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
